// File: rtl/skew_collector.sv
// Collects one column's skewed output stream from the systolic array (DEPTH words) and drains it in arrival order.
// Optional sticky lost-word flag on ovf when SKEW_COLLECTOR_OVF_EN is defined; otherwise ovf is tied low.
module skew_collector #(
   parameter int DW    = 8,
   parameter int DEPTH = 7,
   parameter int IDW   = 3
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   input  logic           shift,
   input  logic [DW-1:0]  shift_in,
   output logic           busy,
   output logic           full,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_data,
   output logic [IDW-1:0] out_id,
   input  logic [IDW-1:0] rd_id,
   output logic [DW-1:0]  rd_data,
   output logic           ovf
);

   // Drain port: out_valid/out_data/out_id form a valid/ready source; a word is
   // consumed on any rising edge where out_valid && out_ready, and the word is
   // held stable while out_valid && !out_ready. out_valid never depends on out_ready.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [IDW:0]   CNT_LAST = (IDW+1)'(DEPTH-1);
   localparam logic [IDW-1:0] PTR_LAST = IDW'(DEPTH-1);
   localparam logic [IDW:0]   DEPTH_W  = (IDW+1)'(DEPTH);

   state_t         state;
   logic [IDW:0]   cnt;
   logic [IDW-1:0] ptr;
   logic [DW-1:0]  mem [DEPTH];
   logic [IDW-1:0] drain_idx;
   logic [IDW-1:0] rd_idx;
   logic           shift_en;

   assign shift_en = (state == FILL) && shift;

   // Newest word enters at mem[0]; arrival index j ends up at mem[DEPTH-1-j].
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (shift_en) begin
         mem[0] <= shift_in;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= '0;
         busy      <= 1'b0;
         full      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= FILL;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            FILL: begin
               if (shift) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     state     <= DRAIN;
                     ptr       <= '0;
                     full      <= 1'b1;
                     out_valid <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (ptr == PTR_LAST) begin
                     state     <= IDLE;
                     ptr       <= '0;
                     busy      <= 1'b0;
                     full      <= 1'b0;
                     out_valid <= 1'b0;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               full      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign drain_idx = PTR_LAST - ptr;
   assign rd_idx    = PTR_LAST - rd_id;
   assign out_id    = ptr;
   assign out_data  = out_valid ? mem[drain_idx] : '0;
   assign rd_data   = ({1'b0, rd_id} < DEPTH_W) ? mem[rd_idx] : '0;

`ifdef SKEW_COLLECTOR_OVF_EN
   // Accepted start in IDLE clears the flag even if a loss is seen on the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf <= 1'b0;
      end else if ((state == IDLE) && start) begin
         ovf <= 1'b0;
      end else if (((state == DRAIN) && shift) || ((state != IDLE) && start)) begin
         ovf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_skew_collector.sv
// Bench for skew_collector: directed frames, a window model of the last DEPTH arrivals, and a drain scoreboard.
`timescale 1ns/1ps
module tb_skew_collector;
   localparam int DW    = 8;
   localparam int DEPTH = 7;
   localparam int IDW   = 3;
`ifdef SKEW_COLLECTOR_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           start = 1'b0;
   logic           shift = 1'b0;
   logic           out_ready = 1'b0;
   logic [DW-1:0]  shift_in = '0;
   logic [IDW-1:0] rd_id = '0;
   logic           busy, full, out_valid, ovf;
   logic [DW-1:0]  out_data, rd_data;
   logic [IDW-1:0] out_id;

   always #5 clk = ~clk;

   skew_collector #(.DW(DW), .DEPTH(DEPTH), .IDW(IDW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .shift(shift), .shift_in(shift_in),
      .busy(busy), .full(full), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id), .rd_id(rd_id), .rd_data(rd_data), .ovf(ovf)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 collecting, 2 draining. win holds the last DEPTH
   // accepted words oldest-first, so arrival index j of a complete frame is win[j].
   int            m_mode = 0;
   int            m_fill = 0;
   int            m_ptr  = 0;
   bit            m_ovf  = 1'b0;
   bit            m_ok   = 1'b0;
   logic [DW-1:0] win[$];
   logic [DW-1:0] exp_q[$];
   logic          seen_valid = 1'b0;
   logic [DW-1:0] seen_data = '0;

   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         m_mode = 0; m_fill = 0; m_ptr = 0; m_ovf = 1'b0;
         win.delete();
         for (int i = 0; i < DEPTH; i++) win.push_back('0);
         m_ok = 1'b1;
      end else begin
         if (m_mode == 0 && start) m_ovf = 1'b0;
         else if ((m_mode == 2 && shift) || (m_mode != 0 && start)) m_ovf = 1'b1;
         case (m_mode)
            0: if (start) begin m_mode = 1; m_fill = 0; end
            1: if (shift) begin
                  win.push_back(shift_in);
                  void'(win.pop_front());
                  m_fill++;
                  if (m_fill == DEPTH) begin m_mode = 2; m_ptr = 0; end
               end
            2: if (out_ready) begin
                  if (exp_q.size() == 0) chk("scoreboard_underflow", 32'(exp_q.size()), 1);
                  else chk("drain_word", {seen_valid, seen_data}, {1'b1, exp_q.pop_front()});
                  m_ptr++;
                  if (m_ptr == DEPTH) begin m_mode = 0; m_ptr = 0; end
               end
            default: m_mode = 0;
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("busy", busy, m_mode != 0);
         chk("full", full, m_mode == 2);
         chk("out_valid", out_valid, m_mode == 2);
         if (m_mode == 2) begin
            chk("out_id", out_id, m_ptr);
            chk("out_data", out_data, win[m_ptr]);
         end
         chk("rd_data", rd_data, (rd_id < DEPTH) ? win[rd_id] : 0);
         chk("ovf", ovf, OVF_ON ? m_ovf : 1'b0);
      end
      seen_valid = out_valid;
      seen_data  = out_data;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic fill(input logic [DW-1:0] base, input logic [DW-1:0] stp, input bit gaps);
      for (int i = 0; i < DEPTH; i++) begin
         shift    = 1'b1;
         shift_in = base + DW'(i) * stp;
         exp_q.push_back(shift_in);
         tick();
         shift = 1'b0;
         if (gaps) tick();
      end
   endtask

   task automatic drain(input bit stall);
      int k = 0;
      while (busy && k < 60) begin
         out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
         tick();
         k++;
      end
      chk("drain_done", busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      rstn = 1'b1;
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_rd", rd_data, 0);
      chk("reset_ovf", ovf, 0);

      // Frame of 0x11..0x77 with ready held high
      out_ready = 1'b1;
      start_frame();
      fill(8'h11, 8'h11, 1'b0);
      chk("t1_full", full, 1);
      chk("t1_id0", out_id, 0);
      chk("t1_data0", out_data, 8'h11);
      repeat (6) tick();
      chk("t1_id6", out_id, 6);
      chk("t1_data6", out_data, 8'h77);
      tick();
      chk("t1_busy_fell", busy, 0);
      out_ready = 1'b0;

      // Gapped fill and stalled drain
      start_frame();
      fill(8'hA0, 8'h01, 1'b1);
      drain(1'b1);

      // Random-read sweep
      start_frame();
      fill(8'h01, 8'h01, 1'b0);
      for (int r = 0; r < 8; r++) begin
         rd_id = IDW'(r);
         #1;
         chk("t3_rd", rd_data, (r < 7) ? r + 1 : 0);
      end
      rd_id = '0;
      drain(1'b0);

      // Asynchronous reset mid-fill
      start_frame();
      for (int i = 0; i < 4; i++) begin
         shift    = 1'b1;
         shift_in = 8'hC1 + DW'(i);
         tick();
      end
      shift = 1'b0;
      rd_id = 3'd6;
      #1 rstn = 1'b0;
      #1;
      chk("t4_busy", busy, 0);
      chk("t4_full", full, 0);
      chk("t4_valid", out_valid, 0);
      chk("t4_id", out_id, 0);
      chk("t4_rd", rd_data, 0);
      tick();
      rstn = 1'b1;
      shift = 1'b1;
      shift_in = 8'h5A;
      repeat (3) tick();
      shift = 1'b0;
      chk("t4_idle", busy, 0);
      chk("t4_rd_after", rd_data, 0);
      rd_id = '0;

      // shift and start during drain are lost
      start_frame();
      fill(8'hD0, 8'h01, 1'b0);
      shift = 1'b1;
      shift_in = 8'hFF;
      start = 1'b1;
      tick();
      shift = 1'b0;
      start = 1'b0;
      rd_id = 3'd6;
      #1;
      chk("t5_full", full, 1);
      chk("t5_id", out_id, 0);
      chk("t5_data", out_data, 8'hD0);
      chk("t5_rd6", rd_data, 8'hD6);
      chk("t5_ovf", ovf, OVF_ON);
      rd_id = '0;
      drain(1'b0);
      chk("t5_ovf_sticky", ovf, OVF_ON);

      // Back-to-back frames, start issued the cycle busy falls
      start_frame();
      chk("t6_ovf_clr", ovf, 0);
      fill(8'hE0, 8'h01, 1'b0);
      drain(1'b0);
      start_frame();
      fill(8'hB0, 8'h01, 1'b0);
      chk("t6_data0", out_data, 8'hB0);
      drain(1'b0);
      #1;
      chk("t6_rd0", rd_data, 8'hB0);
      tick();

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
